tc_bitmem_arbiter: RTL and testbench
====================================

# tc_bitmem_arbiter

Round-robin arbiter and access sequencer that shares one bank of 2^ADDR_W single-bit memory cells between NUM_REQ requesters. It turns per-requester read/write requests into the bank's one-hot save strobes, shared write-data bit and clear signal, and returns read data. Each cell captures save/in on the falling edge and presents its value on the next rising edge. The block sits between the requesting logic and the bit-cell bank. It supports short locked sequences such as read-modify-write, bounded by a lock limit.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 3, cell address width; NUM_CELLS = 2^ADDR_W
- MAX_LOCK, 4, maximum consecutive grants one requester may hold via lock (>=1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  NUM_REQ  access request per requester (level)
- lock  in  NUM_REQ  keep grant next cycle if still requesting
- we  in  NUM_REQ  1 = write, 0 = read
- addr  in  NUM_REQ*ADDR_W  cell address; requester i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ  write bit per requester
- gnt  out  NUM_REQ  registered one-hot grant; all-zero when idle
- rvalid  out  NUM_REQ  one-hot pulse; read data valid for that requester
- rdata  out  1  read data bit, valid when rvalid != 0
- mem_save  out  NUM_CELLS  registered one-hot save strobe to the bank
- mem_in  out  1  registered write bit to the bank
- mem_clr  out  1  active-high bank clear
- mem_out  in  NUM_CELLS  current cell outputs from the bank

## Operation
- FSM states:
  - IDLE: no grant.
  - ACCESS: grant issued by round-robin.
  - HOLD: grant retained through lock.
- Each cycle the arbiter evaluates sampled req/lock and registers one winner.
  - From IDLE or ACCESS: round-robin winner, or IDLE if req == 0.
  - HOLD is taken when the current owner has req and lock high and lock_cnt < MAX_LOCK. This applies from ACCESS or HOLD.
- Round-robin search starts at index (last_owner+1) mod NUM_REQ. After reset last_owner = NUM_REQ-1, so requester 0 has highest priority.
- lock_cnt counts consecutive grants to the same owner.
  - Set to 1 on an ACCESS grant.
  - Incremented on each HOLD grant.
  - When it reaches MAX_LOCK, the owner's lock is ignored for the next decision, which is normal round-robin excluding nothing. If the owner is the only requester, it wins again and lock_cnt restarts at 1.
- On a grant to requester i, the request fields (we_i, addr_i, wdata_i) are registered with gnt.
  - Write: mem_save = one-hot(addr_i), mem_in = wdata_i.
  - Read: mem_save = 0, mem_in = 0, and a read marker with owner and address is stored.
- Read data path: in the grant cycle the block samples mem_out[addr_i] at the closing edge. It presents rdata and a one-hot rvalid[i] for exactly one cycle afterwards.
- A requester wanting one access drops req (or keeps lock low) in the cycle its gnt is high. req still high at the next edge counts as a new request.
- Outputs mem_save, mem_in and gnt are all-zero in IDLE.

## Timing
- Reset (rst low at an edge):
  - gnt = 0, rvalid = 0, rdata = 0, mem_save = 0, mem_in = 0.
  - mem_clr = 1, lock_cnt = 0, state IDLE, last_owner = NUM_REQ-1.
- mem_clr stays 1 while rst is low. It drops at the first edge with rst high.
- Reset asserted mid-access:
  - A write whose mem_save is already high in that cycle may complete in the bank; mem_clr then clears it.
  - A pending read produces no rvalid.
- Latency from req sampled at edge E:
  - gnt and mem_save are high in cycle E+1.
  - rvalid/rdata are high in cycle E+2.
- Write followed by a read of the same cell with the read granted in the next cycle: the read returns the new value. Bank out is updated at the edge closing the write cycle and is sampled in the read grant cycle.
- Maximum throughput: one access per cycle. rvalid from read k may coincide with gnt for access k+1.
- Simultaneous requests resolve within one cycle. There are no bubbles between different owners.

## Test plan
- Reset: hold rst=0 for 3 cycles with req=4'b1111 -> all outputs 0 and mem_clr=1. Release -> mem_clr=0 after 1 edge, then the first gnt=4'b0001.
- Write then read: req0 writes addr 5 with wdata=1, then req0 reads addr 5 next cycle -> mem_save=8'b0010_0000 and mem_in=1 in E+1, then rvalid=4'b0001, rdata=1 in E+3.
- Fairness: req=4'b1111 held constant, lock=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles.
- Lock limit: MAX_LOCK=4, req1 and req2 held high, lock1=1 -> gnt=0010 for 4 cycles, then 0100, then 0010.
- Lone locked owner: only req3 and lock3 high for 10 cycles -> gnt=1000 every cycle with no gaps.
- Reset mid-read: read granted, then rst=0 in the following cycle -> rvalid stays 0 and all outputs return to reset values.

Source files
------------

// File: rtl/tc_bitmem_arbiter.sv
// rtl/tc_bitmem_arbiter.sv - round-robin arbiter and access sequencer for a shared single-bit cell bank
module tc_bitmem_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 3,
  parameter int MAX_LOCK = 4,
  localparam int NUM_CELLS = 1 << ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ-1:0]        wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic                      rdata,
  output logic [NUM_CELLS-1:0]      mem_save,
  output logic                      mem_in,
  output logic                      mem_clr,
  input  logic [NUM_CELLS-1:0]      mem_out
);

  localparam int OW_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t              state_q, state_d;
  logic [OW_W-1:0]     owner_q, owner_d;
  logic [OW_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_CELLS-1:0] save_q, save_d;
  logic                min_q, min_d;
  logic                rd_pend_q, rd_pend_d;
  logic [OW_W-1:0]     rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic                rdata_q, rdata_d;
  logic                clr_q;

  logic                hold_ok;
  logic                rr_found;
  logic [OW_W-1:0]     rr_idx;
  logic [OW_W-1:0]     idx;
  logic [OW_W-1:0]     win;
  logic                grant;
  logic [ADDR_W-1:0]   cur_addr;

  // Next-state: lock hold or round-robin pick, request capture, read return
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    save_d     = '0;
    min_d      = 1'b0;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    rd_addr_d  = rd_addr_q;
    rvalid_d   = '0;
    rdata_d    = 1'b0;
    rr_found   = 1'b0;
    rr_idx     = '0;
    idx        = '0;
    win        = '0;
    grant      = 1'b0;
    cur_addr   = '0;

    // The owner keeps the bank only while it asks for it and has lock budget left
    hold_ok = (state_q != IDLE) && req[owner_q] && lock[owner_q] &&
              (cnt_q < CNT_W'(MAX_LOCK));

    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = OW_W'((int'(last_q) + k) % NUM_REQ);
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_idx   = idx;
      end
    end

    if (hold_ok) begin
      state_d = HOLD;
      win     = owner_q;
      grant   = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (rr_found) begin
      state_d = ACCESS;
      win     = rr_idx;
      grant   = 1'b1;
      cnt_d   = CNT_W'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    if (grant) begin
      gnt_d    = NUM_REQ'(1) << win;
      owner_d  = win;
      last_d   = win;
      cur_addr = addr[int'(win)*ADDR_W +: ADDR_W];
      if (we[win]) begin
        save_d = NUM_CELLS'(1) << cur_addr;
        min_d  = wdata[win];
      end else begin
        rd_pend_d  = 1'b1;
        rd_owner_d = win;
        rd_addr_d  = cur_addr;
      end
    end

    // Bank output is sampled at the edge closing the read grant cycle
    if (rd_pend_q) begin
      rvalid_d = NUM_REQ'(1) << rd_owner_q;
      rdata_d  = mem_out[rd_addr_q];
    end
  end

  // State and output registers; reset drops any pending read and clears the bank
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= OW_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      gnt_q      <= '0;
      save_q     <= '0;
      min_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
      rd_addr_q  <= '0;
      rvalid_q   <= '0;
      rdata_q    <= 1'b0;
      clr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      save_q     <= save_d;
      min_q      <= min_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_addr_q  <= rd_addr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      clr_q      <= 1'b0;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign mem_save = save_q;
  assign mem_in   = min_q;
  assign mem_clr  = clr_q;

endmodule

// File: tb/tb_tc_bitmem_arbiter.sv
// tb/tb_tc_bitmem_arbiter.sv - self-checking bench for tc_bitmem_arbiter with a bit-cell bank model
module tb_tc_bitmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, lock, we, wdata;
  logic [11:0] addr;
  logic [3:0]  gnt, rvalid;
  logic        rdata;
  logic [7:0]  mem_save;
  logic        mem_in, mem_clr;
  logic [7:0]  mem_out;
  logic [7:0]  bank_pend;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0] g;
    logic [3:0] rv;
    logic       rd;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  tc_bitmem_arbiter #(.NUM_REQ(4), .ADDR_W(3), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_save(mem_save), .mem_in(mem_in), .mem_clr(mem_clr), .mem_out(mem_out)
  );

  // Bank: cells capture on the falling edge, present on the next rising edge
  always @(negedge clk)
    bank_pend <= mem_clr ? 8'h00 : ((bank_pend & ~mem_save) | (mem_in ? mem_save : 8'h00));
  always @(posedge clk)
    mem_out <= bank_pend;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; lock = '0; we = '0; wdata = '0; addr = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; lock = '0; we = '0; wdata = '0; addr = '0;
    tick(); tick(); tick();
    total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt); else pass_cnt++;
    total_cnt++; if (rvalid !== 4'b0000) $display("FAIL reset_rvalid got %b exp 0000", rvalid); else pass_cnt++;
    total_cnt++; if (rdata !== 1'b0) $display("FAIL reset_rdata got %b exp 0", rdata); else pass_cnt++;
    total_cnt++; if (mem_save !== 8'h00) $display("FAIL reset_mem_save got %b exp 0", mem_save); else pass_cnt++;
    total_cnt++; if (mem_in !== 1'b0) $display("FAIL reset_mem_in got %b exp 0", mem_in); else pass_cnt++;
    total_cnt++; if (mem_clr !== 1'b1) $display("FAIL reset_mem_clr got %b exp 1", mem_clr); else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++; if (mem_clr !== 1'b0) $display("FAIL release_mem_clr got %b exp 0", mem_clr); else pass_cnt++;
    total_cnt++; if (gnt !== 4'b0001) $display("FAIL release_first_gnt got %b exp 0001", gnt); else pass_cnt++;
    req = '0;
    tick(); tick();
    total_cnt++; if (gnt !== 4'b0000 || mem_save !== 8'h00) $display("FAIL idle_outputs got gnt=%b save=%b exp 0", gnt, mem_save); else pass_cnt++;
  endtask

  task automatic test_write_read();
    do_reset();
    req = 4'b0001; we = 4'b0001; wdata = 4'b0001; addr = 12'd5;
    tick();
    total_cnt++; if (mem_save !== 8'b0010_0000) $display("FAIL wr_mem_save got %b exp 00100000", mem_save); else pass_cnt++;
    total_cnt++; if (mem_in !== 1'b1) $display("FAIL wr_mem_in got %b exp 1", mem_in); else pass_cnt++;
    total_cnt++; if (gnt !== 4'b0001) $display("FAIL wr_gnt got %b exp 0001", gnt); else pass_cnt++;
    we = 4'b0000;
    tick();
    total_cnt++; if (gnt !== 4'b0001 || mem_save !== 8'h00 || mem_in !== 1'b0)
      $display("FAIL rd_grant got gnt=%b save=%b in=%b exp 0001/0/0", gnt, mem_save, mem_in); else pass_cnt++;
    req = '0;
    tick();
    total_cnt++; if (rvalid !== 4'b0001 || rdata !== 1'b1) $display("FAIL rd_return got rv=%b rd=%b exp 0001/1", rvalid, rdata); else pass_cnt++;
    tick();
    total_cnt++; if (rvalid !== 4'b0000) $display("FAIL rd_single_pulse got %b exp 0000", rvalid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  s_req [5];
    logic [3:0]  s_we [5];
    do_reset();
    // cycle0: req0 writes 1 to cell 5; then req1 reads cell 3, req2 reads cell 5
    s_req = '{4'b0001, 4'b0110, 4'b0100, 4'b0000, 4'b0000};
    s_we  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    addr = {3'd0, 3'd5, 3'd3, 3'd5};
    wdata = 4'b0001;
    exp_q.delete();
    exp_q.push_back('{g: 4'b0001, rv: 4'b0000, rd: 1'b0});
    exp_q.push_back('{g: 4'b0010, rv: 4'b0000, rd: 1'b0});
    exp_q.push_back('{g: 4'b0100, rv: 4'b0010, rd: 1'b0});
    exp_q.push_back('{g: 4'b0000, rv: 4'b0100, rd: 1'b1});
    exp_q.push_back('{g: 4'b0000, rv: 4'b0000, rd: 1'b0});
    for (int c = 0; c < 5; c++) begin
      exp_t e;
      req = s_req[c]; we = s_we[c];
      tick();
      if (exp_q.size() == 0) begin
        total_cnt++; $display("FAIL b2b_queue_empty got size 0 exp >0");
      end else begin
        e = exp_q.pop_front();
        total_cnt++;
        if (gnt !== e.g || rvalid !== e.rv || (e.rv != 0 && rdata !== e.rd))
          $display("FAIL b2b_cycle%0d got gnt=%b rv=%b rd=%b exp %b/%b/%b", c, gnt, rvalid, rdata, e.g, e.rv, e.rd);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] prev;
    do_reset();
    req = 4'b1111; lock = '0; we = '0; addr = '0;
    exp_q.delete();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back('{g: 4'b0001, rv: 4'b0000, rd: 1'b0});
    exp_q.push_back('{g: 4'b0010, rv: 4'b0001, rd: 1'b0});
    exp_q.push_back('{g: 4'b0100, rv: 4'b0010, rd: 1'b0});
    exp_q.push_back('{g: 4'b1000, rv: 4'b0100, rd: 1'b0});
    exp_q.push_back('{g: 4'b0001, rv: 4'b1000, rd: 1'b0});
    prev = '0;
    for (int c = 0; c < 5; c++) begin
      exp_t e;
      tick();
      e = exp_q.pop_front();
      total_cnt++;
      if (gnt !== e.g || rvalid !== e.rv || (e.rv != 0 && rdata !== e.rd))
        $display("FAIL fair_cycle%0d got gnt=%b rv=%b exp %b/%b", c, gnt, rvalid, e.g, e.rv);
      else pass_cnt++;
      prev = e.g;
    end
    req = '0;
    tick();
    total_cnt++; if (rvalid !== prev) $display("FAIL fair_last_rvalid got %b exp %b", rvalid, prev); else pass_cnt++;
  endtask

  task automatic test_lock_limit();
    logic [3:0] seq [6];
    do_reset();
    req = 4'b0110; lock = 4'b0010; we = 4'b1111; wdata = '0; addr = '0;
    seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0010};
    exp_q.delete();
    foreach (seq[i]) exp_q.push_back('{g: seq[i], rv: 4'b0000, rd: 1'b0});
    for (int c = 0; c < 6; c++) begin
      exp_t e;
      tick();
      e = exp_q.pop_front();
      total_cnt++;
      if (gnt !== e.g) $display("FAIL lock_cycle%0d got %b exp %b", c, gnt, e.g); else pass_cnt++;
    end
    req = '0; lock = '0;
  endtask

  task automatic test_lone_lock();
    do_reset();
    req = 4'b1000; lock = 4'b1000; we = 4'b1000; wdata = '0; addr = '0;
    exp_q.delete();
    for (int c = 0; c < 10; c++) exp_q.push_back('{g: 4'b1000, rv: 4'b0000, rd: 1'b0});
    for (int c = 0; c < 10; c++) begin
      exp_t e;
      tick();
      e = exp_q.pop_front();
      total_cnt++;
      if (gnt !== e.g) $display("FAIL lone_cycle%0d got %b exp %b", c, gnt, e.g); else pass_cnt++;
    end
    req = '0; lock = '0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req = 4'b0001; we = '0; addr = 12'd5;
    tick();
    total_cnt++; if (gnt !== 4'b0001) $display("FAIL midrd_gnt got %b exp 0001", gnt); else pass_cnt++;
    rst = 1'b0; req = '0;
    tick();
    total_cnt++;
    if (rvalid !== 4'b0000 || gnt !== 4'b0000 || mem_save !== 8'h00 || mem_clr !== 1'b1 || rdata !== 1'b0)
      $display("FAIL midrd_reset got rv=%b gnt=%b save=%b clr=%b exp 0/0/0/1", rvalid, gnt, mem_save, mem_clr);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++; if (rvalid !== 4'b0000) $display("FAIL midrd_no_rvalid got %b exp 0000", rvalid); else pass_cnt++;
  endtask

  initial begin
    bank_pend = '0;
    mem_out = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_fairness();
    test_lock_limit();
    test_lone_lock();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
